// File: rtl/oric_mem_pkg.sv
// Shared types and helpers for the Oric RAM bus to SDRAM port1 bridge.
// Holds the FSM state enum, the captured request struct, byte-enable codes
// and the byte-select helper used for read data return.
package oric_mem_pkg;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  d;
  } req_t;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  // Pick the byte of a 16-bit SDRAM word addressed by CPU address bit 0.
  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic a0);
    return a0 ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/oric_access_detect.sv
// Purpose: turns level strobes on the Oric RAM bus into one-cycle access events.
// Latency: combinational event in the cycle the new access is seen (old values registered).
// Backpressure: none; events are produced regardless of downstream state.
// Ports: clk_sys/reset; ram_cs/ram_oe/ram_we/ram_ad/ram_d from the core;
//        evt pulse and evt_req (addr, we, d) captured at the event.
module oric_access_detect
  import oric_mem_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ram_cs,
  input  logic        ram_oe,
  input  logic        ram_we,
  input  logic [15:0] ram_ad,
  input  logic [7:0]  ram_d,
  output logic        evt,
  output req_t        evt_req
);

  logic        rd, wr;
  logic        rd_old_q, rd_old_d;
  logic        wr_old_q, wr_old_d;
  logic [15:0] ad_old_q, ad_old_d;

  assign rd = ram_cs & ram_oe;
  assign wr = ram_cs & ram_we;

  always_comb begin
    rd_old_d = rd;
    wr_old_d = wr;
    ad_old_d = ram_ad;
    // An address change only re-triggers while a read is held; a held
    // write on a fixed address never repeats.
    evt = (rd & ~rd_old_q) | (wr & ~wr_old_q) | (rd & (ram_ad != ad_old_q));
    // Write wins when both strobes are asserted.
    evt_req.addr = ram_ad;
    evt_req.we   = wr;
    evt_req.d    = ram_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_old_q <= 1'b0;
      wr_old_q <= 1'b0;
      ad_old_q <= 16'h0000;
    end else begin
      rd_old_q <= rd_old_d;
      wr_old_q <= wr_old_d;
      ad_old_q <= ad_old_d;
    end
  end

endmodule

// File: rtl/oric_sdram_bridge.sv
// Purpose: bridges the Oric byte RAM bus to SDRAM port1 (toggle req/ack) with a one-word read cache.
// Latency: request/hit data one cycle after the event; read data registered in the ack cycle.
// Backpressure: one pending slot while waiting for ack; further events dropped (err_overflow).
// Ports: clk_sys/reset; ram_* core bus in, ram_q out; busy/err_overflow/err_timeout status;
//        sd_req/sd_a/sd_ds/sd_we/sd_d out and sd_ack/sd_q in to SDRAM port1.
module oric_sdram_bridge
  import oric_mem_pkg::*;
#(
  parameter int CACHE_EN    = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ram_cs,
  input  logic        ram_oe,
  input  logic        ram_we,
  input  logic [15:0] ram_ad,
  input  logic [7:0]  ram_d,
  output logic [7:0]  ram_q,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_timeout,
  output logic        sd_req,
  input  logic        sd_ack,
  output logic [15:0] sd_a,
  output logic [1:0]  sd_ds,
  output logic        sd_we,
  output logic [15:0] sd_d,
  input  logic [15:0] sd_q
);

  // Counter is loaded with N-1 so the ack is looked for in exactly N WAIT_ACK cycles.
  localparam logic [15:0] TMO_LOAD = 16'(ACK_TIMEOUT - 1);

  logic evt;
  req_t evt_req;

  oric_access_detect u_detect (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ram_cs  (ram_cs),
    .ram_oe  (ram_oe),
    .ram_we  (ram_we),
    .ram_ad  (ram_ad),
    .ram_d   (ram_d),
    .evt     (evt),
    .evt_req (evt_req)
  );

  state_t      state_q, state_d;
  logic        ack_seen_q, ack_seen_d;
  logic        sd_req_q, sd_req_d;
  logic [15:0] sd_a_q, sd_a_d;
  logic [1:0]  sd_ds_q, sd_ds_d;
  logic        sd_we_q, sd_we_d;
  logic [15:0] sd_d_q, sd_d_d;
  logic [7:0]  ram_q_q, ram_q_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_tmo_q, err_tmo_d;
  logic [15:0] cache_q, cache_d;
  logic [14:0] tag_q, tag_d;
  logic        cache_vld_q, cache_vld_d;
  req_t        pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  req_t        cur_q, cur_d;
  logic [15:0] tmo_q, tmo_d;

  logic hit, issue;
  req_t issue_req;

  always_comb begin
    state_d     = state_q;
    ack_seen_d  = ack_seen_q;
    sd_req_d    = sd_req_q;
    sd_a_d      = sd_a_q;
    sd_ds_d     = sd_ds_q;
    sd_we_d     = sd_we_q;
    sd_d_d      = sd_d_q;
    ram_q_d     = ram_q_q;
    err_ovf_d   = err_ovf_q;
    err_tmo_d   = err_tmo_q;
    cache_d     = cache_q;
    tag_d       = tag_q;
    cache_vld_d = cache_vld_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    cur_d       = cur_q;
    tmo_d       = tmo_q;
    issue       = 1'b0;
    issue_req   = pend_q;

    hit = evt && !evt_req.we && (CACHE_EN != 0) && cache_vld_q &&
          (tag_q == evt_req.addr[15:1]);
    if (hit) ram_q_d = byte_sel(cache_q, evt_req.addr[0]);

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          // Pending goes first; a fresh miss in the same cycle takes the freed slot.
          issue      = 1'b1;
          issue_req  = pend_q;
          pend_vld_d = evt && !hit;
          if (evt && !hit) pend_d = evt_req;
        end else if (evt && !hit) begin
          issue     = 1'b1;
          issue_req = evt_req;
        end
      end
      WAIT_ACK: begin
        if (evt && !hit) begin
          if (!pend_vld_q) begin
            pend_d     = evt_req;
            pend_vld_d = 1'b1;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
        if (sd_ack != ack_seen_q) begin
          ack_seen_d = sd_ack;
          state_d    = IDLE;
          if (!cur_q.we) begin
            ram_q_d = byte_sel(sd_q, cur_q.addr[0]);
            if (CACHE_EN != 0) begin
              cache_d     = sd_q;
              tag_d       = cur_q.addr[15:1];
              cache_vld_d = 1'b1;
            end
          end else if (cache_vld_q && (tag_q == cur_q.addr[15:1])) begin
            // Keep the cached word coherent with a write to the same word.
            if (cur_q.addr[0]) cache_d[15:8] = cur_q.d;
            else               cache_d[7:0]  = cur_q.d;
          end
        end else if (tmo_q == 16'd0) begin
          err_tmo_d  = 1'b1;
          ack_seen_d = sd_ack;
          state_d    = IDLE;
          if (!cur_q.we) ram_q_d = 8'hFF;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      cur_d    = issue_req;
      sd_a_d   = issue_req.addr;
      sd_we_d  = issue_req.we;
      sd_d_d   = {issue_req.d, issue_req.d};
      sd_ds_d  = issue_req.we ? (issue_req.addr[0] ? DS_HI : DS_LO) : DS_WORD;
      sd_req_d = ~sd_req_q;
      tmo_d    = TMO_LOAD;
      state_d  = WAIT_ACK;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_seen_q  <= sd_ack;
      sd_req_q    <= 1'b0;
      sd_a_q      <= 16'h0000;
      sd_ds_q     <= DS_WORD;
      sd_we_q     <= 1'b0;
      sd_d_q      <= 16'h0000;
      ram_q_q     <= 8'h00;
      err_ovf_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      cache_q     <= 16'h0000;
      tag_q       <= 15'h0000;
      cache_vld_q <= 1'b0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cur_q       <= '0;
      tmo_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ack_seen_q  <= ack_seen_d;
      sd_req_q    <= sd_req_d;
      sd_a_q      <= sd_a_d;
      sd_ds_q     <= sd_ds_d;
      sd_we_q     <= sd_we_d;
      sd_d_q      <= sd_d_d;
      ram_q_q     <= ram_q_d;
      err_ovf_q   <= err_ovf_d;
      err_tmo_q   <= err_tmo_d;
      cache_q     <= cache_d;
      tag_q       <= tag_d;
      cache_vld_q <= cache_vld_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cur_q       <= cur_d;
      tmo_q       <= tmo_d;
    end
  end

  assign ram_q        = ram_q_q;
  assign busy         = (state_q == WAIT_ACK) | pend_vld_q;
  assign err_overflow = err_ovf_q;
  assign err_timeout  = err_tmo_q;
  assign sd_req       = sd_req_q;
  assign sd_a         = sd_a_q;
  assign sd_ds        = sd_ds_q;
  assign sd_we        = sd_we_q;
  assign sd_d         = sd_d_q;

endmodule
